pc_src_mux4: RTL and testbench

- 4-way, 32-bit data selector that picks the next-PC candidate in the Fetch stage.
- Candidates: sequential PC+4, branch target, jump-index target, register (jr) target.
- The combinational output `out` is the selected value, with no latency.
- A companion registered copy `out_q` (enable-gated, synchronous reset) lets the block act directly as the PC register. `op_q` records the select used for the last registered update.

---
 rtl/pc_src_mux4.sv | 48 ++++
 tb/tb_pc_src_mux4.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/pc_src_mux4.sv
// Next-PC source selector for the Fetch stage.
// Picks one of four 32-bit candidates (PC+4, branch, jump, jr) combinationally
// and keeps an enable-gated registered copy that can serve directly as the PC.
module pc_src_mux4 #(
  parameter int unsigned      WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = 32'h0000_3000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] a2,
  input  logic [WIDTH-1:0] a3,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q,
  output logic [1:0]       op_q,
  output logic [3:0]       sel_onehot
);

  // Power-up values match the reset values so the PC starts at the text base
  // even before the first reset edge.
  logic [WIDTH-1:0] out_r = RESET_VALUE;
  logic [1:0]       op_r  = 2'b00;

  // Ternary tree rather than a case so an unknown op propagates X to out.
  assign out = op[1] ? (op[0] ? a3 : a2)
                     : (op[0] ? a1 : a0);

  // One-hot decode of the select.
  assign sel_onehot = 4'b0001 << op;

  // PC register: reset wins over enable; en=0 stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_r <= RESET_VALUE;
      op_r  <= 2'b00;
    end else if (en) begin
      out_r <= out;
      op_r  <= op;
    end
  end

  assign out_q = out_r;
  assign op_q  = op_r;

endmodule

// File: tb/tb_pc_src_mux4.sv
// Randomized and directed bench for pc_src_mux4 against a behavioural model.
module tb_pc_src_mux4;

  localparam logic [31:0] RV = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        reset, en;
  logic [1:0]  op;
  logic [31:0] a0, a1, a2, a3;
  logic [31:0] out, out_q;
  logic [1:0]  op_q;
  logic [3:0]  sel_onehot;

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model state
  logic [31:0] m_q  = RV;
  logic [1:0]  m_op = 2'b00;

  pc_src_mux4 dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .op         (op),
    .a0         (a0),
    .a1         (a1),
    .a2         (a2),
    .a3         (a3),
    .out        (out),
    .out_q      (out_q),
    .op_q       (op_q),
    .sel_onehot (sel_onehot)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] pick(input logic [1:0] s);
    logic [31:0] c [4];
    c[0] = a0; c[1] = a1; c[2] = a2; c[3] = a3;
    return c[s];
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] s);
    logic [3:0] v = '0;
    for (int i = 0; i < 4; i++) v[i] = (int'(s) == i);
    return v;
  endfunction

  // Drive inputs mid-cycle, then check the combinational outputs.
  task automatic drive(input logic r, input logic e, input logic [1:0] o,
                       input logic [31:0] d0, input logic [31:0] d1,
                       input logic [31:0] d2, input logic [31:0] d3);
    @(negedge clk);
    reset = r; en = e; op = o; a0 = d0; a1 = d1; a2 = d2; a3 = d3;
    #1;
    check("out", out, pick(op));
    check("sel_onehot", {28'h0, sel_onehot}, {28'h0, onehot(op)});
  endtask

  // Advance one edge, update the model, check the registered outputs.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      m_q = RV; m_op = 2'b00;
    end else if (en) begin
      m_q = pick(op); m_op = op;
    end
    #1;
    check("out_q", out_q, m_q);
    check("op_q", {30'h0, op_q}, {30'h0, m_op});
  endtask

  initial begin
    logic [31:0] pc_exp [4];
    pc_exp[0] = 32'h3004; pc_exp[1] = 32'h3008;
    pc_exp[2] = 32'h300C; pc_exp[3] = 32'h3010;

    reset = 1'b0; en = 1'b0; op = 2'b00;
    a0 = '0; a1 = '0; a2 = '0; a3 = '0;
    #1;
    check("powerup_out_q", out_q, RV);
    check("powerup_op_q", {30'h0, op_q}, 32'h0);

    // Static select sweep
    for (int i = 0; i < 4; i++)
      drive(1'b0, 1'b0, 2'(i), 32'h0000_3004, 32'h0000_3010, 32'h0000_0C00, 32'hDEAD_BEEF);

    // Reset with en=1, op=3
    drive(1'b1, 1'b1, 2'd3, 32'h0000_3004, 32'h0000_3010, 32'h0000_0C00, 32'hDEAD_BEEF);
    tick();
    check("reset_out_q", out_q, 32'h0000_3000);
    check("reset_out_live", out, 32'hDEAD_BEEF);

    // Enabled update
    drive(1'b0, 1'b1, 2'd1, 32'h0000_3004, 32'h0000_3010, 32'h0000_0C00, 32'hDEAD_BEEF);
    tick();
    check("en_out_q", out_q, 32'h0000_3010);
    check("en_op_q", {30'h0, op_q}, 32'd1);

    // Stall for three edges, then release
    drive(1'b0, 1'b0, 2'd2, 32'h0000_3004, 32'h0000_3010, 32'h0000_4000, 32'hDEAD_BEEF);
    check("stall_out", out, 32'h0000_4000);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_hold", out_q, 32'h0000_3010);
    end
    drive(1'b0, 1'b1, 2'd2, 32'h0000_3004, 32'h0000_3010, 32'h0000_4000, 32'hDEAD_BEEF);
    tick();
    check("stall_release", out_q, 32'h0000_4000);

    // Sequential PC emulation from reset
    drive(1'b1, 1'b1, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 2'd0, m_q + 32'd4, 32'h0, 32'h0, 32'h0);
      tick();
      check("seq_pc", out_q, pc_exp[i]);
    end

    // Bit-extreme pass-through, then synchronous reset asserted mid-cycle
    drive(1'b0, 1'b1, 2'd3, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 32'h0000_0001);
    tick();
    check("extreme_q3", out_q, 32'h0000_0001);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 2'(i), 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 32'h0000_0001);
      tick();
    end
    check("extreme_q2", out_q, 32'h8000_0000);
    drive(1'b1, 1'b1, 2'd3, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 32'h0000_0001);
    check("sync_reset_hold", out_q, 32'h8000_0000);
    tick();
    check("sync_reset_edge", out_q, 32'h0000_3000);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 9) == 0), 1'($urandom), 2'($urandom),
            $urandom, $urandom, $urandom, $urandom);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
